// File: rtl/sha_msg_schedule.sv
// rtl/sha_msg_schedule.sv - SHA-256 message-schedule expander, one W word per handshake
module sha_msg_schedule #(
    parameter int W_SIZE = 32,
    parameter int ROUNDS = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   blk_valid,
    output logic                   blk_ready,
    input  logic [16*W_SIZE-1:0]   blk_data,
    output logic [W_SIZE-1:0]      w_out,
    output logic [5:0]             w_idx,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic                   w_last,
    output logic                   busy
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [W_SIZE-1:0] window [16];
    logic [5:0]        idx;
    logic              load;
    logic              advance;
    logic [W_SIZE-1:0] new_word;

    function automatic logic [W_SIZE-1:0] rotr(input logic [W_SIZE-1:0] x, input int n);
        return (x >> n) | (x << (W_SIZE - n));
    endfunction

    function automatic logic [W_SIZE-1:0] sig0(input logic [W_SIZE-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [W_SIZE-1:0] sig1(input logic [W_SIZE-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Window slides by one per handshake, so W[t-16..t-1] sit at fixed taps 0/1/9/14.
    assign new_word = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (blk_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (w_ready) begin
                    advance = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                window[i] <= '0;
            end
            idx <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                window[i] <= blk_data[(15 - i)*W_SIZE +: W_SIZE];
            end
            idx <= '0;
        end else if (advance) begin
            for (int i = 0; i < 15; i++) begin
                window[i] <= window[i + 1];
            end
            window[15] <= new_word;
            idx        <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
        end
    end

    assign blk_ready = (state == IDLE);
    assign w_valid   = (state == RUN);
    assign busy      = (state == RUN);
    assign w_last    = (state == RUN) && (idx == LAST_IDX);
    assign w_out     = window[0];
    assign w_idx     = idx;

endmodule

// File: doc/sha_msg_schedule.md
Name: sha_msg_schedule

Overview:
SHA-256 message-schedule expander. It is the producer of the W word that each sha_round stage consumes. It accepts one 512-bit message block and emits the 64 schedule words W[0..63], one per handshake, in order. It sits between the block-input interface and the round datapath, driving the round W input and its enable.

Parameters:
W_SIZE, 32, word width in bits; only 32 is supported.
ROUNDS, 64, number of schedule words emitted per block.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
blk_valid  input  1  a block is presented on blk_data.
blk_ready  output  1  the block can be accepted this cycle.
blk_data  input  512  message block; word 0 in [511:480], word 15 in [31:0], big-endian.
w_out  output  32  current schedule word W[w_idx].
w_idx  output  6  index of w_out, 0..63.
w_valid  output  1  w_out and w_idx are valid.
w_ready  input  1  the downstream round datapath takes w_out this cycle.
w_last  output  1  w_valid and w_idx==63.
busy  output  1  the block is in state RUN.

Behaviour:
- Clock and reset: clock clk; reset is synchronous, active-high.
- Reset values:
  - state=IDLE, window[0..15]=0, idx=0.
  - w_out=0, w_idx=0, w_valid=0, w_last=0, busy=0, blk_ready=1 (the cycle after reset).
- Storage:
  - 16-word register window; window[0] holds W[t].
  - w_out = window[0] and w_idx = idx, both taken directly from registers with no combinational path from inputs.
- State IDLE:
  - blk_ready=1, w_valid=0.
  - On blk_valid&&blk_ready: window[i] <= blk_data word i, idx <= 0, go to RUN.
- State RUN:
  - blk_ready=0, w_valid=1, busy=1.
  - blk_valid is ignored and blk_data is not sampled.
- Word advance: on w_valid&&w_ready,
  - window[i] <= window[i+1] for i=0..14.
  - window[15] <= s1(window[14]) + window[9] + s0(window[1]) + window[0], mod 2^32 (carries discarded).
  - idx <= idx+1.
- Functions:
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Stall: while w_valid && !w_ready, window, idx, w_out and w_idx hold exactly.
- Completion: handshake at idx==63 returns to IDLE. The window's extra word computed at idx 48..63 is never emitted.
- Latency and throughput:
  - W[0] is valid the cycle after block acceptance.
  - With w_ready tied high, 64 consecutive cycles of w_valid.
  - One IDLE cycle follows before the next block can be accepted, giving 65 cycles per block minimum.
- Reset mid-operation: the block is aborted. The next cycle shows w_valid=0, blk_ready=1, idx=0, window cleared. No partial words continue.
- Simultaneous events:
  - reset has priority over any handshake.
  - blk_valid arriving on the same cycle as the idx==63 handshake is not accepted, because blk_ready=0 that cycle.
- w_idx never wraps past 63 within a block; it returns to 0 via IDLE/load.

Test Plan:
1. "abc" padded block (word0=0x61626380, words 1..14=0, word15=0x00000018), w_ready=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB with w_last=1. All 64 words match a software model, on 64 consecutive cycles.
2. All-ones block (0xFFFFFFFF x16) -> W0..W15=0xFFFFFFFF, W16=0x203FFFFC, which checks mod-2^32 wrap.
3. Stall: "abc" block, drop w_ready for 5 cycles at w_idx=20 -> w_out and w_idx frozen at W20 throughout; the sequence resumes unchanged and all 64 words still match.
4. blk_valid held high with a different block during RUN -> blk_ready=0 and the output stream is unaffected. The second block is accepted exactly one cycle after the W63 handshake, and its W0 appears the following cycle.
5. Reset asserted at w_idx=30 -> next cycle w_valid=0, busy=0, blk_ready=1, w_idx=0. A fresh "abc" block then produces the correct W0..W63.
6. Random w_ready (50%) over 100 random blocks -> each block yields exactly 64 handshakes with w_idx 0..63 in order, exactly one w_last per block, and words match the reference model.
